// File: rtl/ecg_pkg.sv
// ---------------------------------------------------------------------------
// ecg_pkg
// Shared definitions for the ECG processing blocks.
//   pd_state_t   : R-peak detector FSM states
//   DEF_*        : default parameter constants for r_peak_detect
//   CNT_W        : width of the search/refractory down-counter
// ---------------------------------------------------------------------------
package ecg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEARCH  = 2'd1,
        ST_REFRACT = 2'd2
    } pd_state_t;

    localparam int DEF_DW      = 8;
    localparam int DEF_SEARCH  = 20;
    localparam int DEF_REFRACT = 200;
    localparam int DEF_RRW     = 16;

    // Wide enough for the largest legal refractory length (65535).
    localparam int CNT_W = 16;

endpackage

// File: rtl/sample_counter.sv
// ---------------------------------------------------------------------------
// sample_counter
// Loadable down-counter that tracks how many valid samples remain in the
// current search or refractory window.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset, clears the count
//   load     in   load load_val (has priority over en)
//   load_val in   CW  number of samples remaining after the loading sample
//   en       in   decrement by one (stops at zero)
//   last     out  the sample being consumed now is the final one of the window
// ---------------------------------------------------------------------------
module sample_counter
    import ecg_pkg::*;
#(
    parameter int CW = CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          last
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    // A count of one means exactly one sample of the window is left,
    // i.e. the sample presented this cycle closes it.
    assign last = (count == CW'(1));

endmodule

// File: rtl/r_peak_detect.sv
// ---------------------------------------------------------------------------
// r_peak_detect
// Slope-triggered R-peak detector for an ECG sample stream.
// A steep first difference opens a fixed-length search window; the largest
// sample within it is reported as the R peak together with the number of
// valid samples since the previous peak. A refractory window then blocks
// re-triggering on the same complex.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   qualifies d_in; nothing advances without it
//   d_in       in   DW    unsigned ECG sample
//   th_slope   in   DW    slope magnitude threshold (0 disables detection)
//   slope_det  out  slope event for the last valid sample
//   diff_out   out  DW+1 two's complement first difference
//   peak_valid out  one-cycle pulse per detected peak
//   peak_amp   out  DW    amplitude of the last peak
//   peak_rr    out  RRW   valid samples between the last two peaks
//   busy       out  high while searching or refractory
// ---------------------------------------------------------------------------
module r_peak_detect
    import ecg_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int SEARCH  = DEF_SEARCH,
    parameter int REFRACT = DEF_REFRACT,
    parameter int RRW     = DEF_RRW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [DW-1:0]  d_in,
    input  logic [DW-1:0]  th_slope,
    output logic           slope_det,
    output logic [DW:0]    diff_out,
    output logic           peak_valid,
    output logic [DW-1:0]  peak_amp,
    output logic [RRW-1:0] peak_rr,
    output logic           busy
);

    localparam logic [CNT_W-1:0] SEARCH_LOAD  = CNT_W'(SEARCH - 1);
    localparam logic [CNT_W-1:0] REFRACT_LOAD = CNT_W'(REFRACT);

    pd_state_t state, state_next;

    logic [DW-1:0]      prev_sample;
    logic               hist_valid;
    logic signed [DW+1:0] diff_ext;
    logic signed [DW+1:0] th_ext;
    logic               slope_now;

    logic [RRW-1:0]     rr_cnt;
    logic [RRW-1:0]     rr_next;
    logic [RRW-1:0]     max_rr;
    logic [RRW-1:0]     since_max;
    logic [RRW-1:0]     since_inc;
    logic [DW-1:0]      run_max;
    logic               first_peak;

    logic               trigger;
    logic               complete;
    logic               upd_max;
    logic               take_max;
    logic [DW-1:0]      fin_max;
    logic [RRW-1:0]     fin_rr;
    logic [RRW-1:0]     fin_since;

    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_load_val;
    logic               cnt_en;
    logic               cnt_last;

    // Differencer: two guard bits keep the difference and the negated
    // threshold exact, so both comparison bounds are inclusive without wrap.
    assign diff_ext  = $signed({2'b00, d_in}) - $signed({2'b00, prev_sample});
    assign th_ext    = $signed({2'b00, th_slope});
    assign slope_now = hist_valid && (th_slope != '0) &&
                       ((diff_ext >= th_ext) || (diff_ext <= -th_ext));

    // Saturating increments for the interval bookkeeping.
    assign rr_next   = (rr_cnt == '1)    ? rr_cnt    : rr_cnt + RRW'(1);
    assign since_inc = (since_max == '1) ? since_max : since_max + RRW'(1);

    // Only a strictly larger sample moves the maximum, so ties keep the
    // earliest position and therefore the shorter interval.
    assign upd_max  = (state == ST_SEARCH) && in_valid && (d_in > run_max);
    assign take_max = trigger || upd_max;

    // Peak values including the sample being consumed right now, since the
    // completing sample may itself be the new maximum.
    assign fin_max   = take_max ? d_in    : run_max;
    assign fin_rr    = take_max ? rr_next : max_rr;
    assign fin_since = take_max ? '0      : since_inc;

    assign busy = (state != ST_IDLE);

    sample_counter #(
        .CW(CNT_W)
    ) u_window_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .last     (cnt_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and window control. The trigger sample is search sample 1,
    // so the counter is loaded with the samples still to come.
    always_comb begin
        state_next   = state;
        trigger      = 1'b0;
        complete     = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid && slope_now) begin
                    trigger  = 1'b1;
                    cnt_load = 1'b1;
                    if (SEARCH == 1) begin
                        complete     = 1'b1;
                        cnt_load_val = REFRACT_LOAD;
                        state_next   = ST_REFRACT;
                    end else begin
                        cnt_load_val = SEARCH_LOAD;
                        state_next   = ST_SEARCH;
                    end
                end
            end
            ST_SEARCH: begin
                if (in_valid) begin
                    if (cnt_last) begin
                        complete     = 1'b1;
                        cnt_load     = 1'b1;
                        cnt_load_val = REFRACT_LOAD;
                        state_next   = ST_REFRACT;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            ST_REFRACT: begin
                if (in_valid) begin
                    if (cnt_last) begin
                        state_next = ST_IDLE;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: difference history, running maximum, interval counter and
    // peak reporting. The peak pulse is registered from the completing
    // sample, so it appears even if in_valid drops on the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_sample <= '0;
            hist_valid  <= 1'b0;
            slope_det   <= 1'b0;
            diff_out    <= '0;
            rr_cnt      <= '0;
            max_rr      <= '0;
            since_max   <= '0;
            run_max     <= '0;
            first_peak  <= 1'b1;
            peak_valid  <= 1'b0;
            peak_amp    <= '0;
            peak_rr     <= '0;
        end else begin
            peak_valid <= complete;
            if (in_valid) begin
                prev_sample <= d_in;
                hist_valid  <= 1'b1;
                slope_det   <= slope_now;
                diff_out    <= hist_valid ? diff_ext[DW:0] : '0;
                rr_cnt      <= rr_next;

                if (take_max) begin
                    run_max   <= d_in;
                    max_rr    <= rr_next;
                    since_max <= '0;
                end else if (state == ST_SEARCH) begin
                    since_max <= since_inc;
                end

                // Re-reference the interval counter to the maximum's
                // position: it now holds the distance from that maximum
                // to the completing sample.
                if (complete) begin
                    peak_amp   <= fin_max;
                    peak_rr    <= first_peak ? '0 : fin_rr;
                    first_peak <= 1'b0;
                    rr_cnt     <= fin_since;
                end
            end
        end
    end

endmodule

// File: tb/tb_r_peak_detect.sv
// ---------------------------------------------------------------------------
// tb_r_peak_detect
// Directed-vector bench for r_peak_detect with DW=8, SEARCH=4, REFRACT=8,
// RRW=16. Sample numbers in the comments count valid samples since the
// initial reset (s1 is the first).
// ---------------------------------------------------------------------------
module tb_r_peak_detect;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  d_in;
    logic [7:0]  th_slope;
    logic        slope_det;
    logic [8:0]  diff_out;
    logic        peak_valid;
    logic [7:0]  peak_amp;
    logic [15:0] peak_rr;
    logic        busy;

    int checks     = 0;
    int errors     = 0;
    int peak_count = 0;

    r_peak_detect #(
        .DW      (8),
        .SEARCH  (4),
        .REFRACT (8),
        .RRW     (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .d_in       (d_in),
        .th_slope   (th_slope),
        .slope_det  (slope_det),
        .diff_out   (diff_out),
        .peak_valid (peak_valid),
        .peak_amp   (peak_amp),
        .peak_rr    (peak_rr),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Compares one observed value against its expected value.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    // Drives one cycle on the falling edge, lets the rising edge consume it,
    // then returns just after the edge so registered outputs can be read.
    task automatic applyStimulus(input logic r, input logic v,
                                 input logic [7:0] d, input logic [7:0] th);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        d_in     = d;
        th_slope = th;
        @(posedge clk);
        #1;
        if (peak_valid === 1'b1) peak_count++;
    endtask

    task automatic sendSample(input logic [7:0] d);
        applyStimulus(1'b0, 1'b1, d, 8'd15);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_slope"}, slope_det, 0);
        checkOutput({tag, "_diff"},  diff_out,  0);
        checkOutput({tag, "_pv"},    peak_valid, 0);
        checkOutput({tag, "_amp"},   peak_amp,  0);
        checkOutput({tag, "_rr"},    peak_rr,   0);
        checkOutput({tag, "_busy"},  busy,      0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        d_in     = 8'd0;
        th_slope = 8'd0;

        applyStimulus(1'b1, 1'b0, 8'd0, 8'd15);
        applyStimulus(1'b1, 1'b0, 8'd0, 8'd15);
        checkAllZero("reset");

        // First complex: 100,100,120,150,140,110.
        sendSample(8'd100);                               // s1
        checkOutput("s1_diff", diff_out, 0);
        checkOutput("s1_slope", slope_det, 0);
        sendSample(8'd100);                               // s2
        checkOutput("s2_slope", slope_det, 0);
        checkOutput("s2_busy", busy, 0);
        sendSample(8'd120);                               // s3 trigger
        checkOutput("s3_slope", slope_det, 1);
        checkOutput("s3_diff", diff_out, 20);
        checkOutput("s3_busy", busy, 1);
        sendSample(8'd150);                               // s4 max
        sendSample(8'd140);                               // s5
        checkOutput("s5_pv", peak_valid, 0);
        sendSample(8'd110);                               // s6 completes search
        checkOutput("p1_pv", peak_valid, 1);
        checkOutput("p1_amp", peak_amp, 150);
        checkOutput("p1_rr", peak_rr, 0);
        checkOutput("p1_busy", busy, 1);

        // Refractory s7..s14 with steep slopes inside it.
        sendSample(8'd100);                               // s7
        checkOutput("p1_pulse_end", peak_valid, 0);
        checkOutput("p1_amp_hold", peak_amp, 150);
        sendSample(8'd200);                               // s8 +100
        checkOutput("ref_slope", slope_det, 1);
        sendSample(8'd100);                               // s9 -100
        for (int i = 10; i <= 13; i++) sendSample(8'd100);
        checkOutput("s13_busy", busy, 1);
        sendSample(8'd100);                               // s14 last refractory
        checkOutput("s14_busy", busy, 0);
        checkOutput("ref_no_peak", peak_count, 1);

        // Flat run to s252, second complex with its max at s254.
        for (int i = 15; i <= 252; i++) sendSample(8'd100);
        checkOutput("flat_busy", busy, 0);
        sendSample(8'd120);                               // s253 trigger
        sendSample(8'd150);                               // s254 max
        sendSample(8'd140);                               // s255
        sendSample(8'd110);                               // s256
        checkOutput("p2_pv", peak_valid, 1);
        checkOutput("p2_amp", peak_amp, 150);
        checkOutput("p2_rr", peak_rr, 250);

        // Refractory s257..s264; the event on s264 is ignored, the one on
        // s265 (ninth after the search) triggers.
        for (int i = 257; i <= 263; i++) sendSample(8'd100);
        sendSample(8'd130);                               // s264 +30
        checkOutput("s264_slope", slope_det, 1);
        checkOutput("s264_busy", busy, 0);
        sendSample(8'd100);                               // s265 -30 trigger, max
        checkOutput("s265_busy", busy, 1);
        checkOutput("s265_diff", diff_out, 482);
        sendSample(8'd100);                               // s266 tie keeps s265
        sendSample(8'd80);                                // s267
        sendSample(8'd70);                                // s268
        checkOutput("p3_amp", peak_amp, 100);
        checkOutput("p3_rr", peak_rr, 11);
        checkOutput("p3_count", peak_count, 3);

        // Threshold boundaries.
        for (int i = 269; i <= 276; i++) sendSample(8'd70);
        sendSample(8'd55);                                // s277 -15 trigger
        checkOutput("m15_slope", slope_det, 1);
        checkOutput("m15_diff", diff_out, 497);
        checkOutput("m15_busy", busy, 1);
        sendSample(8'd60);                                // s278 max
        sendSample(8'd40);                                // s279
        sendSample(8'd40);                                // s280
        checkOutput("p4_amp", peak_amp, 60);
        checkOutput("p4_rr", peak_rr, 13);
        for (int i = 281; i <= 288; i++) sendSample(8'd40);
        sendSample(8'd26);                                // s289 -14
        checkOutput("m14_slope", slope_det, 0);
        checkOutput("m14_diff", diff_out, 498);
        checkOutput("m14_busy", busy, 0);
        applyStimulus(1'b0, 1'b1, 8'd226, 8'd0);          // s290 +200, th=0
        checkOutput("th0_slope", slope_det, 0);
        checkOutput("th0_diff", diff_out, 200);
        checkOutput("th0_busy", busy, 0);
        sendSample(8'd226);                               // s291

        // Search window with two idle cycles inside it.
        sendSample(8'd246);                               // s292 trigger
        sendSample(8'd250);                               // s293 max
        applyStimulus(1'b0, 1'b0, 8'd5, 8'd15);
        applyStimulus(1'b0, 1'b0, 8'd5, 8'd15);
        checkOutput("idle_diff_hold", diff_out, 4);
        checkOutput("idle_pv", peak_valid, 0);
        checkOutput("idle_busy", busy, 1);
        sendSample(8'd240);                               // s294
        checkOutput("s294_pv", peak_valid, 0);
        sendSample(8'd230);                               // s295
        checkOutput("p5_pv", peak_valid, 1);
        checkOutput("p5_amp", peak_amp, 250);
        checkOutput("p5_rr", peak_rr, 15);
        applyStimulus(1'b0, 1'b0, 8'd5, 8'd15);
        checkOutput("p5_pulse_end", peak_valid, 0);

        // Reset on search sample 2 aborts the search.
        for (int i = 296; i <= 303; i++) sendSample(8'd230);
        sendSample(8'd250);                               // s304 trigger
        checkOutput("s304_busy", busy, 1);
        applyStimulus(1'b1, 1'b1, 8'd255, 8'd15);
        checkAllZero("abort");
        checkOutput("abort_count", peak_count, 5);
        sendSample(8'd100);
        checkOutput("post_first_diff", diff_out, 0);
        sendSample(8'd100);
        sendSample(8'd130);                               // trigger
        sendSample(8'd140);
        sendSample(8'd120);
        checkOutput("post_no_peak", peak_count, 5);
        sendSample(8'd110);
        checkOutput("p6_pv", peak_valid, 1);
        checkOutput("p6_amp", peak_amp, 140);
        checkOutput("p6_rr", peak_rr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
